// File: rtl/seg_pkg.sv
// seg_pkg: constants and the hex -> 7-segment table shared by the display blocks.
// Segment encoding is {g,f,e,d,c,b,a}, active-low (0 = segment lit).
package seg_pkg;

   localparam int NUM_DIG = 8;
   localparam int SEL_W   = 3;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [7:0] AN_OFF    = 8'hFF;

   // Entry n is the pattern for hex digit n; listed from F down to 0.
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

   // Slot phase: anodes are held off for the first part of each slot.
   typedef enum logic {
      PH_BLANK = 1'b0,
      PH_DRIVE = 1'b1
   } phase_e;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
      return SEG_TABLE[hex];
   endfunction

endpackage

// File: rtl/hex7seg_dec.sv
// hex7seg_dec: combinational 4-bit hex to active-low 7-segment decoder.
module hex7seg_dec
   import seg_pkg::*;
(
   input  logic [3:0] hex_i,
   output logic [6:0] seg_n_o
);

   assign seg_n_o = hex_to_seg(hex_i);

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 8-digit common-anode 7-segment scan controller.
// Each digit owns a DIV-cycle slot; the first BLANK_CYC cycles of a slot keep
// all anodes off to avoid ghosting. All 8 digits are captured into a shadow
// register at every frame boundary (and when scanning is enabled), so one
// frame never mixes old and new values. an_n/seg_n are registered and lag
// (cnt, sel, shadow) by one cycle.
// Optional build macro: SEG_LZ_BLANK_EN enables leading-zero suppression
// (digits 7..1 that are zero with only zeros above them show no segments).
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int DIV       = 100000,
   parameter int BLANK_CYC = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic [4*NUM_DIG-1:0]   digits,
   output logic [SEL_W-1:0]       sel,
   output logic [NUM_DIG-1:0]     an_n,
   output logic [6:0]             seg_n,
   output logic                   frame_start
);

   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DIV_W-1:0] CNT_LAST  = DIV_W'(DIV - 1);
   localparam logic [DIV_W:0]   BLANK_LIM = (DIV_W + 1)'(BLANK_CYC);
   localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(NUM_DIG - 1);

   logic [DIV_W-1:0]       cnt_q, cnt_d;
   logic [SEL_W-1:0]       sel_q, sel_d;
   logic [4*NUM_DIG-1:0]   shadow_q, shadow_d;
   logic                   en_q;
   logic [NUM_DIG-1:0]     an_n_q, an_n_d;
   logic [6:0]             seg_n_q, seg_n_d;
   logic                   frame_start_q, frame_start_d;

   logic [3:0]             cur_digit;
   logic [6:0]             cur_seg;
   logic [NUM_DIG-1:0]     lz_mask;
   phase_e                 phase;

   // Digit currently selected by the scan, decoded to segments.
   assign cur_digit = shadow_q[{sel_q, 2'b00} +: 4];

   hex7seg_dec u_dec (
      .hex_i   (cur_digit),
      .seg_n_o (cur_seg)
   );

   assign phase = ({1'b0, cnt_q} < BLANK_LIM) ? PH_BLANK : PH_DRIVE;

   // lz_mask[k] marks digit k as a suppressed leading zero.
   genvar gi;
`ifdef SEG_LZ_BLANK_EN
   assign lz_mask[0] = 1'b0;
   generate
      for (gi = 1; gi < NUM_DIG; gi++) begin : g_lz
         assign lz_mask[gi] = ~|shadow_q[4*NUM_DIG-1:4*gi];
      end
   endgenerate
`else
   assign lz_mask = '0;
`endif

   // Prescaler, slot index and shadow capture: start of scan and 7->0 wrap load digits.
   always_comb begin
      cnt_d         = cnt_q;
      sel_d         = sel_q;
      shadow_d      = shadow_q;
      frame_start_d = 1'b0;
      if (!en) begin
         cnt_d = '0;
         sel_d = '0;
      end else if (!en_q) begin
         cnt_d         = '0;
         sel_d         = '0;
         shadow_d      = digits;
         frame_start_d = 1'b1;
      end else if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
         sel_d = sel_q + 1'b1;
         if (sel_q == SEL_LAST) begin
            shadow_d      = digits;
            frame_start_d = 1'b1;
         end
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Output decode from the current registered state; stays dark while parked.
   always_comb begin
      an_n_d  = AN_OFF;
      seg_n_d = SEG_BLANK;
      if (en && en_q && (phase == PH_DRIVE)) begin
         an_n_d  = ~(NUM_DIG'(1) << sel_q);
         seg_n_d = lz_mask[sel_q] ? SEG_BLANK : cur_seg;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q         <= '0;
         sel_q         <= '0;
         shadow_q      <= '0;
         en_q          <= 1'b0;
         an_n_q        <= AN_OFF;
         seg_n_q       <= SEG_BLANK;
         frame_start_q <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         sel_q         <= sel_d;
         shadow_q      <= shadow_d;
         en_q          <= en;
         an_n_q        <= an_n_d;
         seg_n_q       <= seg_n_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign sel         = sel_q;
   assign an_n        = an_n_q;
   assign seg_n       = seg_n_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: bench for seg_scan_ctrl with DIV=10, BLANK_CYC=2.
// A position-based model (cycles since scan start) predicts every output and is
// compared on each falling edge; directed checks pin the model to literal values.
module tb_seg_scan_ctrl;

   localparam int DIV       = 10;
   localparam int BLANK_CYC = 2;
   localparam int NDIG      = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [31:0] digits;
   logic [2:0]  sel;
   logic [7:0]  an_n;
   logic [6:0]  seg_n;
   logic        frame_start;

   int n_checks = 0;
   int n_fail   = 0;

   seg_scan_ctrl #(.DIV(DIV), .BLANK_CYC(BLANK_CYC)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .digits      (digits),
      .sel         (sel),
      .an_n        (an_n),
      .seg_n       (seg_n),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic logic [6:0] hex_seg(input logic [3:0] h);
      case (h)
         4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
         4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
         4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
         4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
      endcase
   endfunction

   bit         m_running = 1'b0;
   int         m_pos = 0;
   logic [3:0] m_sh [NDIG];
   logic [2:0] exp_sel = 3'd0;
   logic [7:0] exp_an = 8'hFF;
   logic [6:0] exp_seg = 7'h7F;
   logic       exp_fs = 1'b0;

   function automatic bit lz_hidden(input int k);
`ifdef SEG_LZ_BLANK_EN
      if (k == 0) return 1'b0;
      for (int j = k; j < NDIG; j++)
         if (m_sh[j] != 4'h0) return 1'b0;
      return 1'b1;
`else
      return (k < 0);
`endif
   endfunction

   task automatic load_shadow();
      for (int k = 0; k < NDIG; k++) m_sh[k] = digits[4*k +: 4];
   endtask

   task automatic model_dark();
      exp_an  = 8'hFF;
      exp_seg = 7'h7F;
   endtask

   task automatic model_step();
      int cnt_prev;
      int dig_prev;
      if (!rst_n) begin
         m_running = 1'b0; m_pos = 0; exp_sel = 3'd0; exp_fs = 1'b0; model_dark();
         for (int k = 0; k < NDIG; k++) m_sh[k] = 4'h0;
      end else if (!en) begin
         m_running = 1'b0; m_pos = 0; exp_sel = 3'd0; exp_fs = 1'b0; model_dark();
      end else if (!m_running) begin
         m_running = 1'b1; m_pos = 0; exp_sel = 3'd0; exp_fs = 1'b1; model_dark();
         load_shadow();
      end else begin
         // outputs show where the scan was one cycle ago
         cnt_prev = m_pos % DIV;
         dig_prev = (m_pos / DIV) % NDIG;
         if (cnt_prev < BLANK_CYC) model_dark();
         else begin
            exp_an  = ~(8'h01 << dig_prev);
            exp_seg = lz_hidden(dig_prev) ? 7'h7F : hex_seg(m_sh[dig_prev]);
         end
         m_pos++;
         exp_sel = 3'((m_pos / DIV) % NDIG);
         exp_fs  = ((m_pos % (NDIG * DIV)) == 0);
         if (exp_fs) load_shadow();
      end
   endtask

   initial forever begin
      @(posedge clk or negedge rst_n);
      model_step();
   end

   // ---------------- per-cycle compare ----------------
   initial forever begin
      @(negedge clk);
      check("model_sel", 32'(sel), 32'(exp_sel));
      check("model_an_n", 32'(an_n), 32'(exp_an));
      check("model_seg_n", 32'(seg_n), 32'(exp_seg));
      check("model_frame_start", 32'(frame_start), 32'(exp_fs));
   end

   // ---------------- directed stimulus ----------------
   logic [6:0] rec_seg [NDIG];
   int         drive_cnt [NDIG];
   int         blank_cnt, fs_cnt, seen_0e;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_rec(input int n);
      for (int k = 0; k < NDIG; k++) begin rec_seg[k] = 7'h7F; drive_cnt[k] = 0; end
      blank_cnt = 0; fs_cnt = 0; seen_0e = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         if (frame_start) fs_cnt++;
         if (an_n == 8'hFF) blank_cnt++;
         else begin
            for (int k = 0; k < NDIG; k++)
               if (!an_n[k]) begin rec_seg[k] = seg_n; drive_cnt[k]++; end
            if (seg_n == 7'h0E) seen_0e++;
         end
      end
   endtask

   initial begin
      int n;
      logic [6:0] exp_t2 [NDIG];
      exp_t2 = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};

      // 1: reset with en held high
      rst_n = 1'b0; en = 1'b1; digits = 32'h76543210;
      repeat (3) tick();
      check("rst_an_n", 32'(an_n), 32'hFF);
      check("rst_seg_n", 32'(seg_n), 32'h7F);
      check("rst_sel", 32'(sel), 32'h0);
      check("rst_frame_start", 32'(frame_start), 32'h0);
      rst_n = 1'b1;
      tick();
      check("start_frame_start", 32'(frame_start), 32'h1);
      n = 0;
      do begin tick(); n++; end while (an_n != 8'hFE && n < 20);
      check("first_drive_latency", 32'(n), 32'd3);

      // 2: rest of the first frame (scan position 3 -> 80)
      run_rec(77);
      for (int k = 0; k < NDIG; k++) check($sformatf("t2_seg_dig%0d", k), 32'(rec_seg[k]), 32'(exp_t2[k]));
      check("t2_drive_cycles_dig3", 32'(drive_cnt[3]), 32'd8);
      check("t2_blank_cycles", 32'(blank_cnt), 32'd14);
      check("t2_frame_pulses", 32'(fs_cnt), 32'd1);
      check("t2_wrap_frame_start", 32'(frame_start), 32'h1);

      // 3: change digits mid-frame at sel=3
      run_rec(30);
      check("t3_sel_at_change", 32'(sel), 32'd3);
      digits = 32'hFFFFFFFF;
      run_rec(50);
      check("t3_no_early_0E", 32'(seen_0e), 32'd0);
      check("t3_old_dig7", 32'(rec_seg[7]), 32'h78);
      check("t3_wrap_pulse", 32'(frame_start), 32'h1);
      run_rec(80);
      check("t3_new_dig0", 32'(rec_seg[0]), 32'h0E);
      check("t3_new_dig7", 32'(rec_seg[7]), 32'h0E);
      check("t3_all_0E_cycles", 32'(seen_0e), 32'd64);
      check("t3_frame_pulses", 32'(fs_cnt), 32'd1);

      // 4: drop en at sel=5, cnt=4
      run_rec(54);
      check("t4_sel_before_drop", 32'(sel), 32'd5);
      en = 1'b0;
      tick();
      check("t4_an_off", 32'(an_n), 32'hFF);
      check("t4_seg_off", 32'(seg_n), 32'h7F);
      check("t4_sel_parked", 32'(sel), 32'd0);
      check("t4_no_pulse", 32'(frame_start), 32'h0);
      repeat (3) tick();
      check("t4_still_parked", 32'(sel), 32'd0);
      en = 1'b1;
      tick();
      check("t4_restart_pulse", 32'(frame_start), 32'h1);
      check("t4_restart_sel", 32'(sel), 32'd0);
      repeat (3) tick();
      check("t4_restart_an_n", 32'(an_n), 32'hFE);
      check("t4_restart_seg_n", 32'(seg_n), 32'h0E);

      // 5: asynchronous reset in the middle of DRIVE
      repeat (2) tick();
      check("t5_driving", 32'(an_n), 32'hFE);
      #2;
      rst_n = 1'b0;
      #1;
      check("t5_async_an_n", 32'(an_n), 32'hFF);
      check("t5_async_seg_n", 32'(seg_n), 32'h7F);
      check("t5_async_sel", 32'(sel), 32'd0);
      check("t5_async_frame_start", 32'(frame_start), 32'h0);

      // 6: leading zeros
      digits = 32'h00000105;
      repeat (2) tick();
      rst_n = 1'b1;
      run_rec(81);
      check("t6_frame_pulses", 32'(fs_cnt), 32'd2);
      check("t6_seg_dig2", 32'(rec_seg[2]), 32'h79);
      check("t6_seg_dig1", 32'(rec_seg[1]), 32'h40);
      check("t6_seg_dig0", 32'(rec_seg[0]), 32'h12);
      check("t6_anode_dig7_active", 32'(drive_cnt[7]), 32'd8);
      for (int k = 3; k < NDIG; k++) begin
`ifdef SEG_LZ_BLANK_EN
         check($sformatf("t6_lz_dig%0d", k), 32'(rec_seg[k]), 32'h7F);
`else
         check($sformatf("t6_zero_dig%0d", k), 32'(rec_seg[k]), 32'h40);
`endif
      end

      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
